mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the Fetch stage (read-only instruction

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types and constants shared by the unified-memory port arbiter.
//   arb_state_t - access FSM state (IDLE -> REQ -> RSP -> IDLE)
//   arb_owner_t - which pipeline port owns the transaction in flight
//   BE_FULL     - byte enables used for every instruction fetch
//   satInc32    - saturating increment used by the optional performance counters
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam logic [3:0] BE_FULL = 4'hF;

    function automatic logic [31:0] satInc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: chooses the winner between fetch (I) and memory-stage (D) requests and
// tracks how many times in a row D has beaten a waiting I.
//   clock, reset  - rising-edge clock, asynchronous active-low reset
//   iReq, dReq    - pending requests from the two ports
//   arbEn         - high while the arbiter is idle and a grant may be taken
//   grantI/grantD - combinational one-hot (or zero) winner
// D wins conflicts because it belongs to the older instruction; once D has won
// STARVE_LIMIT times over a waiting I, the next conflict goes to I.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic iReq,
    input  logic dReq,
    input  logic arbEn,
    output logic grantI,
    output logic grantD
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starveQ;
    logic [3:0] starveD;
    logic       starved;

    assign starved = (starveQ == LIMIT);

    always_comb begin
        grantD = dReq & (~iReq | ~starved);
        grantI = iReq & ~grantD;
    end

    // Counter only moves on cycles where a grant is actually taken.
    always_comb begin
        starveD = starveQ;
        if (arbEn) begin
            if (grantD && iReq) begin
                starveD = starved ? LIMIT : starveQ + 4'd1;
            end else if (grantI) begin
                starveD = 4'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starveQ <= 4'd0;
        end else begin
            starveQ <= starveD;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the fetch read port (I)
// and the load/store port (D). One transaction is in flight at a time.
//   clock, reset           - rising-edge clock, asynchronous active-low reset
//   i_req/i_addr           - fetch request; i_done pulses with i_rdata valid
//   d_req/d_we/d_be/...    - load/store request; d_done pulses on load data / store ack
//   mem_req/we/be/addr/... - registered command toward memory, held until mem_gnt
//   mem_gnt/rvalid/rdata   - memory acceptance and response
//   stall_f, stall_m       - combinational stall requests to the hazard unit
// Optional feature: define ARB_PERF_CNT_EN to add saturating counters perf_conflict
// (cycles with both ports waiting) and perf_forced (starvation-forced I grants).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    // Fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    // Load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    // Memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    // Hazard unit
    output logic              stall_f,
    output logic              stall_m
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_forced
`endif
);

    arb_state_t stateQ;
    arb_owner_t ownerQ;
    logic       squashQ;

    logic grantI;
    logic grantD;
    logic arbEn;
    logic flushing;
    logic rspDone;

    assign arbEn = (stateQ == IDLE);

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clock (clock),
        .reset (reset),
        .iReq  (i_req),
        .dReq  (d_req),
        .arbEn (arbEn),
        .grantI(grantI),
        .grantD(grantD)
    );

    // Fetch withdrew its request while owning the memory: finish the access silently.
    assign flushing = (ownerQ == OWN_I) & ~i_req;

    // Access FSM; every mem_* command output is a register loaded on IDLE -> REQ.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ    <= IDLE;
            ownerQ    <= OWN_NONE;
            squashQ   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (grantD) begin
                        stateQ    <= REQ;
                        ownerQ    <= OWN_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_be    <= d_be;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grantI) begin
                        stateQ    <= REQ;
                        ownerQ    <= OWN_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= BE_FULL;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end
                end
                REQ: begin
                    if (flushing) begin
                        squashQ <= 1'b1;
                    end
                    // Request is never withdrawn once raised.
                    if (mem_gnt) begin
                        stateQ  <= RSP;
                        mem_req <= 1'b0;
                    end
                end
                RSP: begin
                    if (mem_rvalid) begin
                        stateQ  <= IDLE;
                        ownerQ  <= OWN_NONE;
                        squashQ <= 1'b0;
                    end else if (flushing) begin
                        squashQ <= 1'b1;
                    end
                end
                default: begin
                    stateQ <= IDLE;
                    ownerQ <= OWN_NONE;
                end
            endcase
        end
    end

    // Responses outside RSP (e.g. left over from before a reset) are ignored.
    assign rspDone = (stateQ == RSP) & mem_rvalid;

    always_comb begin
        i_done  = rspDone & (ownerQ == OWN_I) & ~squashQ & i_req;
        d_done  = rspDone & (ownerQ == OWN_D);
        stall_f = i_req & ~i_done;
        stall_m = d_req & ~d_done;
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

`ifdef ARB_PERF_CNT_EN
    logic conflictCycle;
    logic forcedGrant;

    assign conflictCycle = stall_f & stall_m;
    // I only beats a pending D when the starvation limit was reached.
    assign forcedGrant   = arbEn & grantI & d_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_conflict <= 32'd0;
            perf_forced   <= 32'd0;
        end else begin
            if (conflictCycle) begin
                perf_conflict <= satInc32(perf_conflict);
            end
            if (forcedGrant) begin
                perf_forced <= satInc32(perf_forced);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of per-cycle vectors followed by
// hand-written sequences for stalls, starvation, flush and mid-access reset.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflict;
    logic [31:0] perf_forced;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .stall_f   (stall_f),
        .stall_m   (stall_m)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflict(perf_conflict),
        .perf_forced  (perf_forced)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string       tag;
        logic        iReq;
        logic [31:0] iAddr;
        logic        dReq;
        logic        dWe;
        logic [3:0]  dBe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        eMemReq;
        logic        eIDone;
        logic        eDDone;
        logic        eStallF;
        logic        eStallM;
        logic        chkCmd;
        logic        eWe;
        logic [3:0]  eBe;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input string tag, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [3:0] db,
        input logic [31:0] da, input logic [31:0] dwd,
        input logic g, input logic rv, input logic [31:0] rd,
        input logic emr, input logic eid, input logic edd, input logic esf, input logic esm,
        input logic ck, input logic ew, input logic [3:0] eb,
        input logic [31:0] ea, input logic [31:0] ewd);
        vec_t v;
        v.tag = tag; v.iReq = ir; v.iAddr = ia; v.dReq = dr; v.dWe = dw; v.dBe = db;
        v.dAddr = da; v.dWdata = dwd; v.gnt = g; v.rvalid = rv; v.rdata = rd;
        v.eMemReq = emr; v.eIDone = eid; v.eDDone = edd; v.eStallF = esf; v.eStallM = esm;
        v.chkCmd = ck; v.eWe = ew; v.eBe = eb; v.eAddr = ea; v.eWdata = ewd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        i_req      = v.iReq;
        i_addr     = v.iAddr;
        d_req      = v.dReq;
        d_we       = v.dWe;
        d_be       = v.dBe;
        d_addr     = v.dAddr;
        d_wdata    = v.dWdata;
        mem_gnt    = v.gnt;
        mem_rvalid = v.rvalid;
        mem_rdata  = v.rdata;
    endtask

    task automatic idleInputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    initial begin
        reset = 1'b0;
        idleInputs();

        // Table: I-only access, stray rvalid in IDLE, D/I conflict (D first), then I.
        vecs.push_back(mkv("stray_rv", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77,
                           0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("i_arb", 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0,
                           0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("i_req", 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0,
                           1, 0, 0, 1, 0, 1, 0, 4'hF, 32'h100, 0));
        vecs.push_back(mkv("i_done", 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 32'h13,
                           0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                           0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("both_arb", 1, 32'h104, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF,
                           0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("d_req", 1, 32'h104, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF,
                           1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF));
        vecs.push_back(mkv("d_done", 1, 32'h104, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF,
                           0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("i_arb2", 1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0,
                           0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("i_req2", 1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 0,
                           1, 0, 0, 1, 0, 1, 0, 4'hF, 32'h104, 0));
        vecs.push_back(mkv("i_done2", 1, 32'h104, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE0001,
                           0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                           0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        chk("rst.mem_req", 32'(mem_req), 0);
        chk("rst.mem_we", 32'(mem_we), 0);
        chk("rst.mem_be", 32'(mem_be), 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        chk("rst.dones", {30'd0, i_done, d_done}, 0);
        reset = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n]);
            #1;
            chk({vecs[n].tag, ".mem_req"}, 32'(mem_req), 32'(vecs[n].eMemReq));
            chk({vecs[n].tag, ".i_done"}, 32'(i_done), 32'(vecs[n].eIDone));
            chk({vecs[n].tag, ".d_done"}, 32'(d_done), 32'(vecs[n].eDDone));
            chk({vecs[n].tag, ".stall_f"}, 32'(stall_f), 32'(vecs[n].eStallF));
            chk({vecs[n].tag, ".stall_m"}, 32'(stall_m), 32'(vecs[n].eStallM));
            if (vecs[n].chkCmd) begin
                chk({vecs[n].tag, ".mem_we"}, 32'(mem_we), 32'(vecs[n].eWe));
                chk({vecs[n].tag, ".mem_be"}, 32'(mem_be), 32'(vecs[n].eBe));
                chk({vecs[n].tag, ".mem_addr"}, mem_addr, vecs[n].eAddr);
                chk({vecs[n].tag, ".mem_wdata"}, mem_wdata, vecs[n].eWdata);
            end
            if (vecs[n].eIDone) chk({vecs[n].tag, ".i_rdata"}, i_rdata, vecs[n].rdata);
            if (vecs[n].eDDone) chk({vecs[n].tag, ".d_rdata"}, d_rdata, vecs[n].rdata);
            @(negedge clock);
        end

        // Grant withheld 10 cycles: command and both stalls must hold steady.
        i_req = 1; i_addr = 32'h108;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h3000; d_wdata = 0;
        #1 chk("gw.arb_mem_req", 32'(mem_req), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            #1;
            chk("gw.mem_req", 32'(mem_req), 1);
            chk("gw.mem_addr", mem_addr, 32'h3000);
            chk("gw.stall_f", 32'(stall_f), 1);
            chk("gw.stall_m", 32'(stall_m), 1);
        end
        @(negedge clock);
        mem_gnt = 1;
        #1 chk("gw.gnt_mem_req", 32'(mem_req), 1);
        @(negedge clock);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55;
        #1;
        chk("gw.d_done", 32'(d_done), 1);
        chk("gw.d_rdata", d_rdata, 32'h55);
        chk("gw.i_done", 32'(i_done), 0);
        @(negedge clock);
        mem_rvalid = 0; d_req = 0;
        @(negedge clock);
        mem_gnt = 1;
        #1 chk("gw.i_addr", mem_addr, 32'h108);
        @(negedge clock);
        mem_gnt = 0; mem_rvalid = 1;
        #1 chk("gw.i_done2", 32'(i_done), 1);
        @(negedge clock);
        idleInputs();
        @(negedge clock);

        // Starvation: D re-requests with I held; the fifth grant must go to I, then D.
        for (int k = 0; k < 6; k++) begin
            automatic logic [31:0] dA = 32'h4000 + 32'(4 * ((k < 4) ? k : 4));
            automatic logic        iWin = (k == 4);
            i_req = (k < 5); i_addr = 32'h200;
            d_req = 1; d_we = 0; d_be = 4'hF; d_addr = dA;
            @(negedge clock);
            mem_gnt = 1;
            #1;
            chk($sformatf("starve%0d.mem_req", k), 32'(mem_req), 1);
            chk($sformatf("starve%0d.mem_addr", k), mem_addr, iWin ? 32'h200 : dA);
            @(negedge clock);
            mem_gnt = 0; mem_rvalid = 1;
            #1;
            chk($sformatf("starve%0d.i_done", k), 32'(i_done), 32'(iWin));
            chk($sformatf("starve%0d.d_done", k), 32'(d_done), 32'(!iWin));
            @(negedge clock);
            mem_rvalid = 0;
        end
        idleInputs();
        @(negedge clock);

        // Flush: fetch drops in RSP and re-requests as the stale response arrives.
        i_req = 1; i_addr = 32'h300;
        @(negedge clock);
        mem_gnt = 1;
        #1 chk("fl.mem_addr", mem_addr, 32'h300);
        @(negedge clock);
        mem_gnt = 0; i_req = 0;
        #1 chk("fl.stall_f_drop", 32'(stall_f), 0);
        @(negedge clock);
        i_req = 1; i_addr = 32'h304; mem_rvalid = 1; mem_rdata = 32'hBAD;
        #1;
        chk("fl.i_done_squashed", 32'(i_done), 0);
        chk("fl.stall_f", 32'(stall_f), 1);
        @(negedge clock);
        mem_rvalid = 0;
        #1 chk("fl.idle_mem_req", 32'(mem_req), 0);
        @(negedge clock);
        mem_gnt = 1;
        #1;
        chk("fl.new_mem_req", 32'(mem_req), 1);
        chk("fl.new_mem_addr", mem_addr, 32'h304);
        @(negedge clock);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h600D;
        #1;
        chk("fl.new_i_done", 32'(i_done), 1);
        chk("fl.new_i_rdata", i_rdata, 32'h600D);
        @(negedge clock);
        idleInputs();
        @(negedge clock);

        // Reset pulsed in RSP, then a stray response after release.
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h5000;
        @(negedge clock);
        mem_gnt = 1;
        #1 chk("rr.mem_addr", mem_addr, 32'h5000);
        @(negedge clock);
        mem_gnt = 0; reset = 0;
        #1;
        chk("rr.mem_req", 32'(mem_req), 0);
        chk("rr.mem_addr_rst", mem_addr, 0);
        @(negedge clock);
        reset = 1; d_req = 0; mem_rvalid = 1; mem_rdata = 32'h99;
        #1;
        chk("rr.d_done", 32'(d_done), 0);
        chk("rr.i_done", 32'(i_done), 0);
        @(negedge clock);
        mem_rvalid = 0; i_req = 1; i_addr = 32'h400;
        #1 chk("rr.idle_mem_req", 32'(mem_req), 0);
        @(negedge clock);
        mem_gnt = 1;
        #1 chk("rr.after_addr", mem_addr, 32'h400);
        @(negedge clock);
        mem_gnt = 0; mem_rvalid = 1;
        #1 chk("rr.after_i_done", 32'(i_done), 1);
        @(negedge clock);
        idleInputs();
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Both done pulses must never coincide.
    always @(negedge clock) begin
        if (reset && i_done && d_done) begin
            errors++;
            $display("FAIL both_dones actual=11 required=not both");
        end
    end

endmodule
